// File: rtl/regfile_2w4r_pkg.sv
// Shared constants and helpers for the dual-issue architectural register file.
//   REG_ADDR_BUS : default register index width
//   REG_BUS      : default register data width
//   REG_NUM      : default number of architectural registers
//   ZERO_REG     : index of the hard-wired zero register
//   slot2_wins() : write-back arbitration between the two write ports
package regfile_2w4r_pkg;

   localparam int unsigned REG_ADDR_BUS = 5;
   localparam int unsigned REG_BUS      = 32;
   localparam int unsigned REG_NUM      = 2 ** REG_ADDR_BUS;
   localparam int unsigned ZERO_REG     = 0;

   // Slot 2 wins unless slot 1 alone carries the younger tag. Equal tags are
   // illegal and resolve to slot 2.
   function automatic logic slot2_wins(input logic wnum1, input logic wnum2);
      return wnum2 | ~wnum1;
   endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational operand read port with write-through bypass.
//   raddr            : register index to read
//   we*/waddr*/wdata*/wnum* : both same-cycle write-back ports with order tags
//   mem_word         : stored value of mem[raddr]
//   busy_bit         : scoreboard bit of raddr
//   rdata            : x0 -> 0, else bypassed write data, else stored value
//   rbusy            : pending producer, masked by a same-cycle write and for x0
module rf_read_port
   import regfile_2w4r_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = REG_BUS,
   parameter int unsigned ADDR_WIDTH = REG_ADDR_BUS
) (
   input  logic [ADDR_WIDTH-1:0] raddr,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] waddr1,
   input  logic [DATA_WIDTH-1:0] wdata1,
   input  logic                  wnum1,
   input  logic                  we2,
   input  logic [ADDR_WIDTH-1:0] waddr2,
   input  logic [DATA_WIDTH-1:0] wdata2,
   input  logic                  wnum2,
   input  logic [DATA_WIDTH-1:0] mem_word,
   input  logic                  busy_bit,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rbusy
);

   logic is_zero;
   logic hit1;
   logic hit2;

   assign is_zero = (raddr == ADDR_WIDTH'(ZERO_REG));
   assign hit1    = we1 && (waddr1 == raddr);
   assign hit2    = we2 && (waddr2 == raddr);

   always_comb begin
      rdata = mem_word;
      rbusy = 1'b0;
      if (is_zero) begin
         rdata = '0;
      end else begin
         if (hit1 && hit2) begin
            rdata = slot2_wins(wnum1, wnum2) ? wdata2 : wdata1;
         end else if (hit2) begin
            rdata = wdata2;
         end else if (hit1) begin
            rdata = wdata1;
         end
         // The write retiring this cycle is the producer the bit was waiting on.
         rbusy = busy_bit && !(hit1 || hit2);
      end
   end

endmodule

// File: rtl/regfile_2w4r.sv
// Architectural integer register file for the dual-issue pipeline.
//   clk, rst_n                  : core clock, asynchronous active-low reset
//   we/waddr/wdata/wnum 1,2     : conflict-resolved write-back ports with order tags
//   iss_we/iss_waddr 1,2        : destinations issued this cycle (scoreboard set)
//   raddr0..3 / rdata0..3       : combinational operand reads with write bypass
//   rbusy0..3                   : source still has a pending producer
module regfile_2w4r
   import regfile_2w4r_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = REG_BUS,
   parameter int unsigned ADDR_WIDTH = REG_ADDR_BUS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we1,
   input  logic                  we2,
   input  logic [ADDR_WIDTH-1:0] waddr1,
   input  logic [ADDR_WIDTH-1:0] waddr2,
   input  logic [DATA_WIDTH-1:0] wdata1,
   input  logic [DATA_WIDTH-1:0] wdata2,
   input  logic                  wnum1,
   input  logic                  wnum2,
   input  logic                  iss_we1,
   input  logic                  iss_we2,
   input  logic [ADDR_WIDTH-1:0] iss_waddr1,
   input  logic [ADDR_WIDTH-1:0] iss_waddr2,
   input  logic [ADDR_WIDTH-1:0] raddr0,
   input  logic [ADDR_WIDTH-1:0] raddr1,
   input  logic [ADDR_WIDTH-1:0] raddr2,
   input  logic [ADDR_WIDTH-1:0] raddr3,
   output logic [DATA_WIDTH-1:0] rdata0,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [DATA_WIDTH-1:0] rdata2,
   output logic [DATA_WIDTH-1:0] rdata3,
   output logic                  rbusy0,
   output logic                  rbusy1,
   output logic                  rbusy2,
   output logic                  rbusy3
);

   localparam int unsigned Depth = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [Depth];
   logic [DATA_WIDTH-1:0] mem_d [Depth];
   logic [Depth-1:0]      busy_q;
   logic [Depth-1:0]      busy_d;

   // Writes are suppressed during reset so the bypass cannot leak data out.
   logic we1_live;
   logic we2_live;
   logic w1_en;
   logic w2_en;

   assign we1_live = we1 && rst_n;
   assign we2_live = we2 && rst_n;

   // Only the winning port updates storage on a same-address double write.
   always_comb begin
      w1_en = we1_live && (waddr1 != ADDR_WIDTH'(ZERO_REG));
      w2_en = we2_live && (waddr2 != ADDR_WIDTH'(ZERO_REG));
      if (w1_en && w2_en && (waddr1 == waddr2)) begin
         if (slot2_wins(wnum1, wnum2)) begin
            w1_en = 1'b0;
         end else begin
            w2_en = 1'b0;
         end
      end
   end

   always_comb begin
      mem_d = mem_q;
      if (w1_en) mem_d[waddr1] = wdata1;
      if (w2_en) mem_d[waddr2] = wdata2;
   end

   // Clears first, then sets: a newly issued producer is younger than the
   // one retiring on the same index.
   always_comb begin
      busy_d = busy_q;
      if (we1_live) busy_d[waddr1] = 1'b0;
      if (we2_live) busy_d[waddr2] = 1'b0;
      if (iss_we1)  busy_d[iss_waddr1] = 1'b1;
      if (iss_we2)  busy_d[iss_waddr2] = 1'b1;
      busy_d[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q  <= '{default: '0};
         busy_q <= '0;
      end else begin
         mem_q  <= mem_d;
         busy_q <= busy_d;
      end
   end

   logic [ADDR_WIDTH-1:0] raddr_arr [4];
   logic [DATA_WIDTH-1:0] rdata_arr [4];
   logic [3:0]            rbusy_arr;

   assign raddr_arr[0] = raddr0;
   assign raddr_arr[1] = raddr1;
   assign raddr_arr[2] = raddr2;
   assign raddr_arr[3] = raddr3;

   for (genvar k = 0; k < 4; k++) begin : g_rd
      rf_read_port #(
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH)
      ) u_rd (
         .raddr    (raddr_arr[k]),
         .we1      (we1_live),
         .waddr1   (waddr1),
         .wdata1   (wdata1),
         .wnum1    (wnum1),
         .we2      (we2_live),
         .waddr2   (waddr2),
         .wdata2   (wdata2),
         .wnum2    (wnum2),
         .mem_word (mem_q[raddr_arr[k]]),
         .busy_bit (busy_q[raddr_arr[k]]),
         .rdata    (rdata_arr[k]),
         .rbusy    (rbusy_arr[k])
      );
   end

   assign rdata0 = rdata_arr[0];
   assign rdata1 = rdata_arr[1];
   assign rdata2 = rdata_arr[2];
   assign rdata3 = rdata_arr[3];
   assign rbusy0 = rbusy_arr[0];
   assign rbusy1 = rbusy_arr[1];
   assign rbusy2 = rbusy_arr[2];
   assign rbusy3 = rbusy_arr[3];

endmodule

// File: tb/tb_regfile_2w4r.sv
module tb_regfile_2w4r;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        we1, we2, wnum1, wnum2, iss_we1, iss_we2;
   logic [4:0]  waddr1, waddr2, iss_waddr1, iss_waddr2;
   logic [31:0] wdata1, wdata2;
   logic [4:0]  raddr0, raddr1, raddr2, raddr3;
   logic [31:0] rdata0, rdata1, rdata2, rdata3;
   logic        rbusy0, rbusy1, rbusy2, rbusy3;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   regfile_2w4r #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (5)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .we1        (we1),
      .we2        (we2),
      .waddr1     (waddr1),
      .waddr2     (waddr2),
      .wdata1     (wdata1),
      .wdata2     (wdata2),
      .wnum1      (wnum1),
      .wnum2      (wnum2),
      .iss_we1    (iss_we1),
      .iss_we2    (iss_we2),
      .iss_waddr1 (iss_waddr1),
      .iss_waddr2 (iss_waddr2),
      .raddr0     (raddr0),
      .raddr1     (raddr1),
      .raddr2     (raddr2),
      .raddr3     (raddr3),
      .rdata0     (rdata0),
      .rdata1     (rdata1),
      .rdata2     (rdata2),
      .rdata3     (rdata3),
      .rbusy0     (rbusy0),
      .rbusy1     (rbusy1),
      .rbusy2     (rbusy2),
      .rbusy3     (rbusy3)
   );

   // Equal program-order tags on a double write are illegal.
   always @(posedge clk) begin
      if (rst_n && we1 && we2) begin
         assert (wnum1 != wnum2)
            else $error("illegal write-back tags: wnum1 == wnum2 == %0b", wnum1);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow a further #1.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we1 = 0; we2 = 0; iss_we1 = 0; iss_we2 = 0;
      waddr1 = 0; waddr2 = 0; wdata1 = 0; wdata2 = 0;
      wnum1 = 0; wnum2 = 1; iss_waddr1 = 0; iss_waddr2 = 0;
   endtask

   initial begin
      idle();
      raddr0 = 0; raddr1 = 0; raddr2 = 0; raddr3 = 0;
      rst_n = 0;
      tick();
      tick();

      // Reset state over every index, on all four ports.
      for (int i = 0; i < 32; i++) begin
         raddr0 = 5'(i); raddr1 = 5'(i); raddr2 = 5'(i); raddr3 = 5'(i);
         #1;
         check($sformatf("rst_rdata0[%0d]", i), rdata0, 32'h0);
         check($sformatf("rst_rdata3[%0d]", i), rdata3, 32'h0);
         check($sformatf("rst_rbusy1[%0d]", i), {31'b0, rbusy1}, 32'h0);
         check($sformatf("rst_rbusy2[%0d]", i), {31'b0, rbusy2}, 32'h0);
      end
      rst_n = 1;
      raddr0 = 5'd5;
      #1;
      check("first_cycle_rdata", rdata0, 32'h0);
      check("first_cycle_rbusy", {31'b0, rbusy0}, 32'h0);

      // Bypass, then stored value.
      tick();
      we1 = 1; waddr1 = 5'd5; wdata1 = 32'hDEADBEEF; raddr0 = 5'd5;
      #1;
      check("bypass_w1", rdata0, 32'hDEADBEEF);
      tick();
      idle();
      #1;
      check("stored_w1", rdata0, 32'hDEADBEEF);
      check("stored_w1_busy", {31'b0, rbusy0}, 32'h0);

      // Same-address conflict, slot 2 younger.
      we1 = 1; we2 = 1; waddr1 = 5'd7; waddr2 = 5'd7;
      wdata1 = 32'h11; wdata2 = 32'h22; wnum1 = 0; wnum2 = 1; raddr1 = 5'd7;
      #1;
      check("conflict_s2_bypass", rdata1, 32'h22);
      tick();
      idle();
      #1;
      check("conflict_s2_stored", rdata1, 32'h22);

      // Same-address conflict, slot 1 younger.
      we1 = 1; we2 = 1; waddr1 = 5'd7; waddr2 = 5'd7;
      wdata1 = 32'h11; wdata2 = 32'h22; wnum1 = 1; wnum2 = 0;
      #1;
      check("conflict_s1_bypass", rdata1, 32'h11);
      tick();
      idle();
      #1;
      check("conflict_s1_stored", rdata1, 32'h11);

      // x0 ignores writes and issue marks.
      we1 = 1; waddr1 = 5'd0; wdata1 = 32'hFFFF_FFFF;
      iss_we1 = 1; iss_waddr1 = 5'd0; raddr2 = 5'd0;
      #1;
      check("x0_same_rdata", rdata2, 32'h0);
      check("x0_same_rbusy", {31'b0, rbusy2}, 32'h0);
      tick();
      idle();
      #1;
      check("x0_next_rdata", rdata2, 32'h0);
      check("x0_next_rbusy", {31'b0, rbusy2}, 32'h0);
      tick();
      check("x0_later_rbusy", {31'b0, rbusy2}, 32'h0);

      // Scoreboard set by issue, cleared by write-back.
      iss_we1 = 1; iss_waddr1 = 5'd9; raddr3 = 5'd9;
      #1;
      check("sb_issue_same", {31'b0, rbusy3}, 32'h0);
      tick();
      idle();
      #1;
      check("sb_issue_next", {31'b0, rbusy3}, 32'h1);
      tick();
      check("sb_issue_hold", {31'b0, rbusy3}, 32'h1);
      we2 = 1; waddr2 = 5'd9; wdata2 = 32'h99;
      #1;
      check("sb_wb_same_busy", {31'b0, rbusy3}, 32'h0);
      check("sb_wb_same_data", rdata3, 32'h99);
      tick();
      idle();
      #1;
      check("sb_wb_next_busy", {31'b0, rbusy3}, 32'h0);
      check("sb_wb_next_data", rdata3, 32'h99);

      // Set beats clear on the same index.
      we1 = 1; waddr1 = 5'd12; wdata1 = 32'h00C0FFEE;
      iss_we2 = 1; iss_waddr2 = 5'd12; raddr0 = 5'd12;
      #1;
      check("setclr_same_busy", {31'b0, rbusy0}, 32'h0);
      tick();
      idle();
      #1;
      check("setclr_next_busy", {31'b0, rbusy0}, 32'h1);
      check("setclr_next_data", rdata0, 32'h00C0FFEE);

      // All ports read independently.
      raddr0 = 5'd5; raddr1 = 5'd7; raddr2 = 5'd9; raddr3 = 5'd12;
      #1;
      check("multi_rd0", rdata0, 32'hDEADBEEF);
      check("multi_rd1", rdata1, 32'h11);
      check("multi_rd2", rdata2, 32'h99);
      check("multi_rd3", rdata3, 32'h00C0FFEE);
      check("multi_bz3", {31'b0, rbusy3}, 32'h1);
      check("multi_bz2", {31'b0, rbusy2}, 32'h0);

      // Asynchronous reset mid-stream, away from any clock edge.
      #2;
      rst_n = 0;
      #1;
      check("arst_rd0", rdata0, 32'h0);
      check("arst_rd1", rdata1, 32'h0);
      check("arst_rd2", rdata2, 32'h0);
      check("arst_rd3", rdata3, 32'h0);
      check("arst_bz3", {31'b0, rbusy3}, 32'h0);
      // Write and issue presented during reset must be discarded.
      we1 = 1; waddr1 = 5'd20; wdata1 = 32'hA5A5A5A5;
      iss_we1 = 1; iss_waddr1 = 5'd20; raddr0 = 5'd20;
      #1;
      check("arst_bypass_blocked", rdata0, 32'h0);
      tick();
      idle();
      rst_n = 1;
      #1;
      check("arst_write_dropped", rdata0, 32'h0);
      check("arst_issue_dropped", {31'b0, rbusy0}, 32'h0);
      tick();
      check("post_rst_rd3", rdata3, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
